// File: rtl/key_note_select.sv
// key_note_select: synchronises and debounces 8 piano keys, then selects the
// highest pressed key and presents its half-period count to the tone divider.
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   keys[7:0]    raw asynchronous keys, active-high, bit0=C4 .. bit7=C5
//   half_period  divider compare value for the selected note, 0 when silent
//   note_on      gate, high while the accepted key vector is nonzero
//   note_idx     index of the highest key in the accepted vector
//   note_change  one-cycle pulse when note_on or note_idx changes
//   busy         high while a candidate key vector is being debounced
module key_note_select #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       keys,
    output logic [CNT_W-1:0] half_period,
    output logic             note_on,
    output logic [2:0]       note_idx,
    output logic             note_change,
    output logic             busy
);

    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HALF_CLK = CLK_HZ / 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMING   = 2'd1,
        PLAY     = 2'd2,
        CHANGING = 2'd3
    } state_t;

    logic [7:0]      s1, s2, s_prev, stable;
    logic [DB_W-1:0] cnt;
    state_t          state, state_nxt;
    logic            accept_c;
    logic            new_on_c;
    logic [2:0]      new_idx_c;

    // Half-period count for each note: (CLK_HZ/2)/f_note, truncated
    function automatic logic [CNT_W-1:0] half_of(input logic [2:0] idx);
        case (idx)
            3'd0:    half_of = CNT_W'(HALF_CLK / 262);
            3'd1:    half_of = CNT_W'(HALF_CLK / 294);
            3'd2:    half_of = CNT_W'(HALF_CLK / 330);
            3'd3:    half_of = CNT_W'(HALF_CLK / 349);
            3'd4:    half_of = CNT_W'(HALF_CLK / 392);
            3'd5:    half_of = CNT_W'(HALF_CLK / 440);
            3'd6:    half_of = CNT_W'(HALF_CLK / 494);
            default: half_of = CNT_W'(HALF_CLK / 523);
        endcase
    endfunction

    // Highest set bit wins; 0 when no key is set
    function automatic logic [2:0] top_key(input logic [7:0] v);
        top_key = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) top_key = 3'(i);
        end
    endfunction

    // A candidate is accepted once it has held unchanged for the full window
    assign accept_c  = (s2 != stable) && (s2 == s_prev) &&
                       (cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign new_on_c  = |stable;
    assign new_idx_c = top_key(stable);

    // Synchroniser, debounce counter and accepted vector
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1     <= '0;
            s2     <= '0;
            s_prev <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            s1     <= keys;
            s2     <= s1;
            s_prev <= s2;
            if ((s2 == stable) || (s2 != s_prev)) begin
                cnt <= '0;
            end else if (accept_c) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

    // State register, busy registered alongside it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ARMING) || (state_nxt == CHANGING);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s2 != 8'd0) state_nxt = ARMING;
            end
            ARMING: begin
                if (s2 == 8'd0)    state_nxt = IDLE;
                else if (accept_c) state_nxt = PLAY;
            end
            PLAY: begin
                if (s2 != stable) state_nxt = CHANGING;
            end
            CHANGING: begin
                if (s2 == stable)  state_nxt = PLAY;
                else if (accept_c) state_nxt = (s2 == 8'd0) ? IDLE : PLAY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Note outputs follow the accepted vector one cycle later
    always_ff @(posedge clk) begin
        if (!reset) begin
            note_on     <= 1'b0;
            note_idx    <= 3'd0;
            half_period <= '0;
            note_change <= 1'b0;
        end else begin
            note_on     <= new_on_c;
            note_idx    <= new_idx_c;
            half_period <= new_on_c ? half_of(new_idx_c) : '0;
            // Pulse only when the gate flips or the sounding key moves
            note_change <= (new_on_c != note_on) ||
                           (new_on_c && (new_idx_c != note_idx));
        end
    end

endmodule

// File: tb/tb_key_note_select.sv
module tb_key_note_select;

    localparam int unsigned CNT_W = 25;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [7:0]       keys = 8'h00;
    logic [CNT_W-1:0] half_period;
    logic             note_on;
    logic [2:0]       note_idx;
    logic             note_change;
    logic             busy;

    int checks = 0;
    int errors = 0;

    key_note_select #(
        .CLK_HZ(50_000_000),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys(keys),
        .half_period(half_period),
        .note_on(note_on),
        .note_idx(note_idx),
        .note_change(note_change),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        keys  = 8'hFF;
        tick(2);
        checks++; if (note_on !== 1'b0) begin errors++; $display("FAIL reset_note_on got %0b want 0", note_on); end
        checks++; if (note_idx !== 3'd0) begin errors++; $display("FAIL reset_note_idx got %0d want 0", note_idx); end
        checks++; if (half_period !== 25'd0) begin errors++; $display("FAIL reset_half_period got %0d want 0", half_period); end
        checks++; if (note_change !== 1'b0) begin errors++; $display("FAIL reset_note_change got %0b want 0", note_change); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        reset = 1'b1;
        tick(7);
        checks++; if (note_on !== 1'b0) begin errors++; $display("FAIL reset_early_note_on got %0b want 0", note_on); end
        tick(1);
        checks++; if (note_on !== 1'b1) begin errors++; $display("FAIL reset_ff_note_on got %0b want 1", note_on); end
        checks++; if (note_idx !== 3'd7) begin errors++; $display("FAIL reset_ff_idx got %0d want 7", note_idx); end
        checks++; if (half_period !== 25'd47801) begin errors++; $display("FAIL reset_ff_hp got %0d want 47801", half_period); end
        checks++; if (note_change !== 1'b1) begin errors++; $display("FAIL reset_ff_change got %0b want 1", note_change); end
        tick(1);
        checks++; if (note_change !== 1'b0) begin errors++; $display("FAIL reset_ff_change_end got %0b want 0", note_change); end
    endtask

    task automatic test_release(input string name);
        keys = 8'h00;
        tick(8);
        checks++; if (note_on !== 1'b0) begin errors++; $display("FAIL %s_note_on got %0b want 0", name, note_on); end
        checks++; if (half_period !== 25'd0) begin errors++; $display("FAIL %s_hp got %0d want 0", name, half_period); end
        checks++; if (note_change !== 1'b1) begin errors++; $display("FAIL %s_change got %0b want 1", name, note_change); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %0b want 0", name, busy); end
        tick(1);
        checks++; if (note_change !== 1'b0) begin errors++; $display("FAIL %s_change_end got %0b want 0", name, note_change); end
    endtask

    task automatic test_single_key();
        keys = 8'h01;
        tick(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b want 1", busy); end
        checks++; if (note_on !== 1'b0) begin errors++; $display("FAIL single_hold_on got %0b want 0", note_on); end
        tick(3);
        checks++; if (note_on !== 1'b1) begin errors++; $display("FAIL single_note_on got %0b want 1", note_on); end
        checks++; if (note_idx !== 3'd0) begin errors++; $display("FAIL single_idx got %0d want 0", note_idx); end
        checks++; if (half_period !== 25'd95419) begin errors++; $display("FAIL single_hp got %0d want 95419", half_period); end
        checks++; if (note_change !== 1'b1) begin errors++; $display("FAIL single_change got %0b want 1", note_change); end
        tick(1);
        checks++; if (note_change !== 1'b0) begin errors++; $display("FAIL single_change_end got %0b want 0", note_change); end
    endtask

    task automatic test_add_higher();
        int pulses;
        keys = 8'h81;
        tick(8);
        checks++; if (note_idx !== 3'd7) begin errors++; $display("FAIL higher_idx got %0d want 7", note_idx); end
        checks++; if (half_period !== 25'd47801) begin errors++; $display("FAIL higher_hp got %0d want 47801", half_period); end
        checks++; if (note_change !== 1'b1) begin errors++; $display("FAIL higher_change got %0b want 1", note_change); end
        tick(1);
        keys = 8'h80;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (note_change === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL lower_release_pulses got %0d want 0", pulses); end
        checks++; if (note_idx !== 3'd7) begin errors++; $display("FAIL lower_release_idx got %0d want 7", note_idx); end
        checks++; if (half_period !== 25'd47801) begin errors++; $display("FAIL lower_release_hp got %0d want 47801", half_period); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lower_release_busy got %0b want 0", busy); end
    endtask

    task automatic test_glitch();
        int pulses;
        int on_seen;
        int busy_seen;
        keys = 8'h04;
        tick(3);
        keys = 8'h00;
        pulses = 0;
        on_seen = 0;
        busy_seen = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (note_change === 1'b1) pulses++;
            if (note_on === 1'b1) on_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        checks++; if (busy_seen == 0) begin errors++; $display("FAIL glitch_busy_rise got %0d cycles want >0", busy_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %0b want 0", busy); end
        checks++; if (on_seen !== 0) begin errors++; $display("FAIL glitch_note_on got %0d cycles want 0", on_seen); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_priority();
        int pulses;
        keys = 8'h16;
        tick(8);
        checks++; if (note_idx !== 3'd4) begin errors++; $display("FAIL prio_idx got %0d want 4", note_idx); end
        checks++; if (half_period !== 25'd63775) begin errors++; $display("FAIL prio_hp got %0d want 63775", half_period); end
        checks++; if (note_change !== 1'b1) begin errors++; $display("FAIL prio_change got %0b want 1", note_change); end
        tick(1);
        keys = 8'h12;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (note_change === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL prio_release_pulses got %0d want 0", pulses); end
        checks++; if (half_period !== 25'd63775) begin errors++; $display("FAIL prio_release_hp got %0d want 63775", half_period); end
    endtask

    task automatic test_play_e4();
        keys = 8'h04;
        tick(12);
        checks++; if (note_idx !== 3'd2) begin errors++; $display("FAIL e4_idx got %0d want 2", note_idx); end
        checks++; if (half_period !== 25'd75757) begin errors++; $display("FAIL e4_hp got %0d want 75757", half_period); end
    endtask

    task automatic test_reset_mid();
        keys = 8'h20;
        tick(12);
        checks++; if (note_idx !== 3'd5) begin errors++; $display("FAIL a4_idx got %0d want 5", note_idx); end
        checks++; if (half_period !== 25'd56818) begin errors++; $display("FAIL a4_hp got %0d want 56818", half_period); end
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        checks++; if (note_on !== 1'b0) begin errors++; $display("FAIL mid_reset_on got %0b want 0", note_on); end
        checks++; if (note_idx !== 3'd0) begin errors++; $display("FAIL mid_reset_idx got %0d want 0", note_idx); end
        checks++; if (half_period !== 25'd0) begin errors++; $display("FAIL mid_reset_hp got %0d want 0", half_period); end
        checks++; if (note_change !== 1'b0) begin errors++; $display("FAIL mid_reset_change got %0b want 0", note_change); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %0b want 0", busy); end
        tick(1);
        checks++; if (note_change !== 1'b0) begin errors++; $display("FAIL post_reset_change got %0b want 0", note_change); end
        checks++; if (note_on !== 1'b0) begin errors++; $display("FAIL post_reset_on got %0b want 0", note_on); end
    endtask

    initial begin
        test_reset();
        test_release("clear");
        test_single_key();
        test_add_higher();
        test_release("release_c5");
        test_glitch();
        test_priority();
        test_release("release_g4");
        test_play_e4();
        test_release("release_e4");
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
